// File: rtl/relu_requant_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant_if : tile-in / row-out handshake bundle for relu_requant |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface relu_requant_if #(
  parameter int COLS   = 5,
  parameter int AB_BW  = 25,
  parameter int OUT_BW = 8
);
  localparam int RW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                        i_valid;
  logic                        o_ready;
  logic [AB_BW*COLS*COLS-1:0]  i_acc_bias;
  logic [3:0]                  i_shift;
  logic                        o_valid;
  logic                        i_ready;
  logic [OUT_BW*COLS-1:0]      o_act;
  logic [RW-1:0]               o_row_idx;
  logic                        o_last;

  modport slave (
    input  i_valid, i_acc_bias, i_shift, i_ready,
    output o_ready, o_valid, o_act, o_row_idx, o_last
  );

  modport master (
    output i_valid, i_acc_bias, i_shift, i_ready,
    input  o_ready, o_valid, o_act, o_row_idx, o_last
  );
endinterface
`default_nettype wire

// File: rtl/relu_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_requant : ReLU + rounding shift + unsigned saturate, row stream |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module relu_requant #(
  parameter int COLS   = 5,
  parameter int AB_BW  = 25,
  parameter int OUT_BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  relu_requant_if.slave bus
);
  localparam int RW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = AB_BW * COLS;
  localparam int TILE_W = ROW_W * COLS;
  localparam logic [AB_BW:0] c_sat = (AB_BW+1)'((1 << OUT_BW) - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [TILE_W-1:0]       tile_q, tile_d;
  logic [3:0]              shift_q, shift_d;
  logic                    valid_q, valid_d;
  logic [OUT_BW*COLS-1:0]  act_q, act_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    last_q, last_d;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_advance;
  logic [RW-1:0]           w_next_row;
  logic [TILE_W-1:0]       w_src_tile;
  logic [3:0]              w_src_shift;
  logic [RW-1:0]           w_src_row;
  logic [ROW_W-1:0]        w_rows [COLS];
  logic [ROW_W-1:0]        w_row_sel;
  logic [OUT_BW*COLS-1:0]  w_req_row;

  assign w_ready   = en && (state_q == S_IDLE || (valid_q && bus.i_ready && last_q));
  assign w_accept  = bus.i_valid && w_ready;
  assign w_advance = valid_q && bus.i_ready && en;

  // One requant datapath serves both row 0 of an incoming tile and row idx+1 of the held tile.
  assign w_next_row  = last_q ? '0 : row_q + RW'(1);
  assign w_src_tile  = w_accept ? bus.i_acc_bias : tile_q;
  assign w_src_shift = w_accept ? bus.i_shift    : shift_q;
  assign w_src_row   = w_accept ? '0             : w_next_row;

  generate
    for (genvar r = 0; r < COLS; r++) begin : g_row
      assign w_rows[r] = w_src_tile[r*ROW_W +: ROW_W];
    end
  endgenerate

  assign w_row_sel = w_rows[w_src_row];

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [AB_BW-1:0] w_x;
      logic [AB_BW:0]          w_rnd;
      logic [AB_BW:0]          w_sum;
      logic [AB_BW:0]          w_shr;

      assign w_x   = w_row_sel[c*AB_BW +: AB_BW];
      assign w_rnd = (w_src_shift == 4'd0) ? '0 : ((AB_BW+1)'(1) << (w_src_shift - 4'd1));
      // Extra MSB keeps the rounding add from overflowing for the largest positive input.
      assign w_sum = {1'b0, w_x} + w_rnd;
      assign w_shr = w_sum >> w_src_shift;
      assign w_req_row[c*OUT_BW +: OUT_BW] =
          (w_x[AB_BW-1] || (w_x == '0)) ? '0 :
          (w_shr > c_sat)               ? '1 :
                                          w_shr[OUT_BW-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    shift_d = shift_q;
    valid_d = valid_q;
    act_d   = act_q;
    row_d   = row_q;
    last_d  = last_q;

    if (w_accept) begin
      state_d = S_STREAM;
      tile_d  = bus.i_acc_bias;
      shift_d = bus.i_shift;
      valid_d = 1'b1;
      act_d   = w_req_row;
      row_d   = '0;
      last_d  = (COLS == 1);
    end else if (w_advance) begin
      if (last_q) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end else begin
        act_d  = w_req_row;
        row_d  = w_next_row;
        last_d = (w_next_row == RW'(COLS - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      act_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      row_q   <= row_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_valid   = valid_q;
  assign bus.o_act     = act_q;
  assign bus.o_row_idx = row_q;
  assign bus.o_last    = last_q;
endmodule
`default_nettype wire

// File: tb/tb_relu_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_relu_requant : directed + random bench with row scoreboard        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_relu_requant;
  localparam int COLS   = 5;
  localparam int AB_BW  = 25;
  localparam int OUT_BW = 8;
  localparam int RW     = 3;
  localparam int TILE_W = AB_BW * COLS * COLS;
  localparam int ACT_W  = OUT_BW * COLS;

  typedef struct packed {
    logic [ACT_W-1:0] act;
    logic [RW-1:0]    idx;
    logic             last;
  } row_t;

  logic clk;
  logic rst_n;
  logic en;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  row_t exp_q[$];

  relu_requant_if #(.COLS(COLS), .AB_BW(AB_BW), .OUT_BW(OUT_BW)) bus ();

  relu_requant #(.COLS(COLS), .AB_BW(AB_BW), .OUT_BW(OUT_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the element rule, in 64-bit integers.
  function automatic logic [OUT_BW-1:0] ref_elem(input longint x, input int s);
    longint y;
    if (x <= 0) return '0;
    y = (x + ((s > 0) ? (longint'(1) << (s - 1)) : 64'sd0)) >> s;
    if (y > (2**OUT_BW - 1)) y = 2**OUT_BW - 1;
    return OUT_BW'(y);
  endfunction

  function automatic void push_tile(input logic [TILE_W-1:0] t, input logic [3:0] s);
    row_t e;
    logic signed [AB_BW-1:0] x;
    for (int r = 0; r < COLS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        x = t[(r*COLS + c)*AB_BW +: AB_BW];
        e.act[c*OUT_BW +: OUT_BW] = ref_elem(longint'(x), int'(s));
      end
      e.idx  = RW'(r);
      e.last = (r == COLS - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [AB_BW-1:0] rand_elem();
    int v;
    case ($urandom_range(0, 3))
      0:       v = -int'($urandom_range(1, 1000000));
      1:       v = int'($urandom_range(0, 600));
      2:       v = int'($urandom_range(0, (1 << 24) - 1));
      default: v = int'($urandom);
    endcase
    return AB_BW'(v);
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < COLS*COLS; i++) t[i*AB_BW +: AB_BW] = rand_elem();
    return t;
  endfunction

  function automatic logic [TILE_W-1:0] fill_tile(input int v);
    logic [TILE_W-1:0] t;
    for (int i = 0; i < COLS*COLS; i++) t[i*AB_BW +: AB_BW] = AB_BW'(v);
    return t;
  endfunction

  // Scoreboard: front of exp_q is the row that must be on o_act while valid.
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      ev = (exp_q.size() != 0);
      er = en && (!ev || (bus.i_ready && exp_q.size() == 1));
      check("o_valid", 64'(bus.o_valid), 64'(ev));
      check("o_ready", 64'(bus.o_ready), 64'(er));
      if (ev) begin
        check("o_act",     64'(bus.o_act),     64'(exp_q[0].act));
        check("o_row_idx", 64'(bus.o_row_idx), 64'(exp_q[0].idx));
        check("o_last",    64'(bus.o_last),    64'(exp_q[0].last));
        if (bus.i_ready && en) void'(exp_q.pop_front());
      end
      if (bus.i_valid && er) push_tile(bus.i_acc_bias, bus.i_shift);
    end
  end

  // Returns one step after the accepting edge, with row 0 on the outputs.
  task automatic send_tile(input logic [TILE_W-1:0] t, input logic [3:0] s);
    bit ok = 1'b0;
    bus.i_valid    = 1'b1;
    bus.i_acc_bias = t;
    bus.i_shift    = s;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_valid    = 1'b0;
    bus.i_acc_bias = rand_tile();
    bus.i_shift    = 4'($urandom);
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    int           c0;
    logic [31:0]  edge_v   [5] = '{-5, 0, 3, 1000, (1 << 24) - 1};
    logic [3:0]   edge_s   [5] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd15};
    logic [7:0]   edge_exp [5] = '{8'd0, 8'd0, 8'd2, 8'd255, 8'd255};
    logic [TILE_W-1:0] tb2;
    logic [3:0]        sb2;
    bit                busy;

    rst_n          = 1'b0;
    en             = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_acc_bias = '0;
    bus.i_shift    = '0;

    // Reset values; o_ready tracks en while idle
    #1;
    check("rst_o_valid",   64'(bus.o_valid),   64'd0);
    check("rst_o_act",     64'(bus.o_act),     64'd0);
    check("rst_o_row_idx", 64'(bus.o_row_idx), 64'd0);
    check("rst_o_last",    64'(bus.o_last),    64'd0);
    check("rst_ready_en1", 64'(bus.o_ready),   64'd1);
    en = 1'b0;
    #1;
    check("rst_ready_en0", 64'(bus.o_ready),   64'd0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All-300 tile, shift 1: five rows of 150 then idle
    send_tile(fill_tile(300), 4'd1);
    for (int r = 0; r < COLS; r++) begin
      check("t300_act",  64'(bus.o_act),     64'({COLS{8'd150}}));
      check("t300_idx",  64'(bus.o_row_idx), 64'(r));
      check("t300_last", 64'(bus.o_last),    64'(r == COLS - 1));
      @(posedge clk);
      #1;
    end
    check("t300_idle", 64'(bus.o_valid), 64'd0);

    // Rounding and saturation corner values
    for (int i = 0; i < 5; i++) begin
      send_tile(fill_tile(int'(edge_v[i])), edge_s[i]);
      check("edge_act", 64'(bus.o_act), 64'({COLS{edge_exp[i]}}));
    end
    wait_idle();

    // Two tiles back to back: second accepted exactly COLS cycles after the first
    send_tile(rand_tile(), 4'($urandom));
    c0 = cyc;
    send_tile(rand_tile(), 4'($urandom));
    check("b2b_gap", 64'(cyc - c0), 64'(COLS));
    wait_idle();

    // Downstream stalls with a 1,0,0 ready pattern
    busy = 1'b1;
    fork
      begin
        send_tile(rand_tile(), 4'($urandom));
        send_tile(rand_tile(), 4'($urandom));
        wait_idle();
        busy = 1'b0;
      end
      begin
        for (int k = 0; busy && k < 200; k++) begin
          bus.i_ready = (k % 3 == 0);
          @(posedge clk);
          #1;
        end
        bus.i_ready = 1'b1;
      end
    join

    // Enable dropped for three cycles mid-stream with a tile pending
    send_tile(rand_tile(), 4'($urandom));
    tb2 = rand_tile();
    sb2 = 4'($urandom);
    bus.i_valid    = 1'b1;
    bus.i_acc_bias = tb2;
    bus.i_shift    = sb2;
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    send_tile(tb2, sb2);
    wait_idle();

    // Asynchronous reset at row 2, then a fresh tile from row 0
    send_tile(rand_tile(), 4'($urandom));
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_idx", 64'(bus.o_row_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_valid),   64'd0);
    check("mid_rst_act",   64'(bus.o_act),     64'd0);
    check("mid_rst_idx",   64'(bus.o_row_idx), 64'd0);
    check("mid_rst_last",  64'(bus.o_last),    64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_tile(rand_tile(), 4'($urandom));
    check("post_rst_valid", 64'(bus.o_valid),   64'd1);
    check("post_rst_idx",   64'(bus.o_row_idx), 64'd0);
    wait_idle();

    // Random soak with random downstream readiness
    busy = 1'b1;
    fork
      begin
        for (int t = 0; t < 8; t++) send_tile(rand_tile(), 4'($urandom));
        wait_idle();
        busy = 1'b0;
      end
      begin
        for (int k = 0; busy && k < 2000; k++) begin
          bus.i_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.i_ready = 1'b1;
      end
    join
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
